// File: rtl/anc_pkg.sv
// Shared ANC definitions: FSM state encoding, sample width, output clamp
// limits and sign-magnitude <-> two's-complement conversion helpers.
package anc_pkg;

    localparam int unsigned SAMPLE_W  = 11;
    localparam int          CLAMP_MAX = 1023;
    localparam int          CLAMP_MIN = -1023;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UPDATE = 3'd1,
        MAC    = 3'd2,
        DONE   = 3'd3,
        PULSE  = 3'd4
    } state_t;

    // Sign-magnitude to two's complement; a negative zero maps to 0.
    function automatic logic signed [SAMPLE_W-1:0] sm_to_tc(input logic [SAMPLE_W-1:0] sm);
        logic signed [SAMPLE_W-1:0] mag;
        mag = {1'b0, sm[SAMPLE_W-2:0]};
        return sm[SAMPLE_W-1] ? -mag : mag;
    endfunction

    // Two's complement (already within +/-1023) to sign-magnitude; 0 -> +0.
    function automatic logic [SAMPLE_W-1:0] tc_to_sm(input logic signed [SAMPLE_W-1:0] v);
        logic [SAMPLE_W-1:0] neg;
        neg = -v;
        return v[SAMPLE_W-1] ? {1'b1, neg[SAMPLE_W-2:0]} : v;
    endfunction

endpackage

// File: rtl/anc_sm_clamp.sv
// Scales a wide signed accumulator down by FRAC bits (floor), clamps it to
// +/-1023 and returns the sign-magnitude sample.
//   acc      in   ACC_W  signed accumulator
//   result_c out  11     clamped sign-magnitude result (combinational)
module anc_sm_clamp
    import anc_pkg::*;
#(
    parameter int unsigned ACC_W = 31,
    parameter int unsigned FRAC  = 12
) (
    input  logic signed [ACC_W-1:0]    acc,
    output logic        [SAMPLE_W-1:0] result_c
);

    localparam logic signed [ACC_W-1:0] HI = ACC_W'(CLAMP_MAX);
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(CLAMP_MIN);

    logic signed [ACC_W-1:0]    y;
    logic signed [SAMPLE_W-1:0] y_sat;

    // Floor scale, saturate, encode.
    always_comb begin
        y = acc >>> FRAC;
        if (y > HI) begin
            y_sat = SAMPLE_W'(CLAMP_MAX);
        end else if (y < LO) begin
            y_sat = SAMPLE_W'(CLAMP_MIN);
        end else begin
            y_sat = y[SAMPLE_W-1:0];
        end
        result_c = tc_to_sm(y_sat);
    end

endmodule

// File: rtl/anc_lms_fir.sv
// Adaptive LMS FIR stage with one time-multiplexed MAC.
// Optional feature macro: ANC_LMS_ADAPT_EN (LMS coefficient adaptation).
// Without it the coefficients are a fixed pass-through (w[0] = 1.0).
//   Clk_100M     in   1   clock, rising edge
//   Reset        in   1   synchronous active-high reset
//   RefIn        in   11  reference sample, sign-magnitude
//   SampleValid  in   1   strobe qualifying RefIn/Err
//   Err          in   11  error feedback, sign-magnitude
//   FiltOut      out  11  filter result, sign-magnitude, held between results
//   FiltComplete out  1   one-cycle result strobe
//   Busy         out  1   high outside IDLE
//   Overrun      out  1   sticky, sample arrived while busy
module anc_lms_fir
    import anc_pkg::*;
#(
    parameter int unsigned TAPS      = 16,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned COEF_FRAC = 12,
    parameter int unsigned MU_SHIFT  = 6
) (
    input  logic                Clk_100M,
    input  logic                Reset,
    input  logic [SAMPLE_W-1:0] RefIn,
    input  logic                SampleValid,
    input  logic [SAMPLE_W-1:0] Err,
    output logic [SAMPLE_W-1:0] FiltOut,
    output logic                FiltComplete,
    output logic                Busy,
    output logic                Overrun
);

    localparam int unsigned     IDX_W = $clog2(TAPS);
    localparam int unsigned     ACC_W = COEF_W + SAMPLE_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(TAPS - 1);

    state_t                     state, next_state;
    logic [IDX_W-1:0]           k;
    logic                       last;
    logic signed [SAMPLE_W-1:0] x [TAPS];
    logic signed [SAMPLE_W-1:0] ref_q;
    logic signed [COEF_W-1:0]   w [TAPS];
    logic signed [ACC_W-1:0]    acc;
    logic [SAMPLE_W-1:0]        out_c;
    logic                       latch_en, shift_en, mac_en, load_en;

    assign last = (k == LAST);

    // State register.
    always_ff @(posedge Clk_100M) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic; DONE spans two cycles so FiltOut settles before the strobe.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (SampleValid) next_state = UPDATE;
            UPDATE: begin
`ifdef ANC_LMS_ADAPT_EN
                if (last) next_state = MAC;
`else
                next_state = MAC;
`endif
            end
            MAC:    if (last) next_state = DONE;
            DONE:   if (k == IDX_W'(1)) next_state = PULSE;
            PULSE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath control decode.
    always_comb begin
        latch_en = 1'b0;
        shift_en = 1'b0;
        mac_en   = 1'b0;
        load_en  = 1'b0;
        case (state)
            IDLE:   latch_en = SampleValid;
            UPDATE: shift_en = (next_state == MAC);
            MAC:    mac_en   = 1'b1;
            DONE:   load_en  = (k == '0);
            default: ;
        endcase
    end

    anc_sm_clamp #(.ACC_W(ACC_W), .FRAC(COEF_FRAC)) u_clamp (
        .acc      (acc),
        .result_c (out_c)
    );

    // Tap counter, delay line, accumulator and registered outputs.
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            k            <= '0;
            ref_q        <= '0;
            acc          <= '0;
            FiltOut      <= '0;
            FiltComplete <= 1'b0;
            Busy         <= 1'b0;
            Overrun      <= 1'b0;
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
        end else begin
            k <= (next_state != state) ? '0 : k + 1'b1;
            if (latch_en) ref_q <= sm_to_tc(RefIn);
            if (shift_en) begin
                x[0] <= ref_q;
                for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
            end
            // Clearing on the shift cycle is the entry into MAC.
            if (shift_en)    acc <= '0;
            else if (mac_en) acc <= acc + ACC_W'(w[k]) * ACC_W'(x[k]);
            if (load_en) FiltOut <= out_c;
            FiltComplete <= (next_state == PULSE);
            Busy         <= (next_state != IDLE);
            if (SampleValid && (state != IDLE)) Overrun <= 1'b1;
        end
    end

`ifdef ANC_LMS_ADAPT_EN
    localparam int unsigned PROD_W = 2 * SAMPLE_W;
    localparam int unsigned SUM_W  = ((COEF_W > PROD_W) ? COEF_W : PROD_W) + 1;
    localparam logic signed [SUM_W-1:0] W_MAX = SUM_W'((2 ** (COEF_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] W_MIN = SUM_W'(-(2 ** (COEF_W - 1)));

    logic signed [SAMPLE_W-1:0] err_q;
    logic signed [PROD_W-1:0]   prod, delta;
    logic signed [SUM_W-1:0]    sum;
    logic signed [COEF_W-1:0]   w_new;

    // LMS step for tap k with saturating add (reads x before the shift).
    always_comb begin
        prod  = PROD_W'(err_q) * PROD_W'(x[k]);
        delta = prod >>> MU_SHIFT;
        sum   = SUM_W'(w[k]) + SUM_W'(delta);
        if (sum > W_MAX)      w_new = COEF_W'(W_MAX);
        else if (sum < W_MIN) w_new = COEF_W'(W_MIN);
        else                  w_new = sum[COEF_W-1:0];
    end

    // Error latch and coefficient memory.
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            err_q <= '0;
            for (int i = 0; i < TAPS; i++) w[i] <= '0;
        end else begin
            if (latch_en)         err_q <= sm_to_tc(Err);
            if (state == UPDATE)  w[k]  <= w_new;
        end
    end
`else
    logic unused_err;
    assign unused_err = ^Err;

    // Fixed pass-through coefficients.
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            if (i == 0) w[i] = COEF_W'(2 ** COEF_FRAC);
            else        w[i] = '0;
        end
    end
`endif

endmodule

// File: tb/tb_anc_lms_fir.sv
// Self-checking bench for anc_lms_fir: directed spec cases plus randomized
// samples against an integer reference model of the LMS filter.
module tb_anc_lms_fir;

    localparam int TAPS      = 16;
    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 12;
    localparam int MU_SHIFT  = 6;
`ifdef ANC_LMS_ADAPT_EN
    localparam bit ADAPT = 1'b1;
`else
    localparam bit ADAPT = 1'b0;
`endif
    localparam int EXP_LAT = ADAPT ? 2 * TAPS + 3 : TAPS + 4;
    localparam int MIN_GAP = EXP_LAT + 1;
    localparam int RST_CYC = ADAPT ? TAPS + 4 : 8;

    logic        clk;
    logic        rst;
    logic [10:0] ref_in;
    logic        sample_valid;
    logic [10:0] err;
    logic [10:0] filt_out;
    logic        filt_complete;
    logic        busy;
    logic        overrun;

    int n_checks;
    int n_pass;
    int mx [TAPS];
    int mw [TAPS];
    bit exp_ovr;

    anc_lms_fir #(
        .TAPS(TAPS), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .MU_SHIFT(MU_SHIFT)
    ) dut (
        .Clk_100M     (clk),
        .Reset        (rst),
        .RefIn        (ref_in),
        .SampleValid  (sample_valid),
        .Err          (err),
        .FiltOut      (filt_out),
        .FiltComplete (filt_complete),
        .Busy         (busy),
        .Overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int sm2int(input logic [10:0] v);
        int m;
        m = int'(v[9:0]);
        return v[10] ? -m : m;
    endfunction

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) begin
            mx[i] = 0;
            mw[i] = (!ADAPT && i == 0) ? (1 << COEF_FRAC) : 0;
        end
    endfunction

    // One accepted sample: adapt, shift, filter; returns sign-magnitude output.
    function automatic int model_step(input logic [10:0] r, input logic [10:0] e);
        int ev, nw, acc, y;
        ev = sm2int(e);
        if (ADAPT) begin
            for (int i = 0; i < TAPS; i++) begin
                nw = mw[i] + floor_div(ev * mx[i], 1 << MU_SHIFT);
                if (nw > 32767)  nw = 32767;
                if (nw < -32768) nw = -32768;
                mw[i] = nw;
            end
        end
        for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = sm2int(r);
        acc = 0;
        for (int i = 0; i < TAPS; i++) acc += mw[i] * mx[i];
        y = floor_div(acc, 1 << COEF_FRAC);
        if (y > 1023)  y = 1023;
        if (y < -1023) y = -1023;
        return (y < 0) ? (1024 + (-y)) : y;
    endfunction

    // Issue one sample and observe the window until the next sample slot.
    task automatic run_sample(input logic [10:0] r, input logic [10:0] e,
                              input int ovr_cyc, input int gap, input int fixed);
        int          exp_out, lat, pulses;
        logic [10:0] at_pulse, pre;
        exp_out = model_step(r, e);
        if (fixed >= 0) exp_out = fixed;
        lat = 0; pulses = 0; at_pulse = '0; pre = 'x;
        @(negedge clk);
        check("busy_at_accept", busy, 0);
        ref_in = r; err = e; sample_valid = 1'b1;
        for (int n = 1; n < gap; n++) begin
            @(negedge clk);
            sample_valid = (n == ovr_cyc);
            ref_in = 11'($urandom);
            err    = 11'($urandom);
            if (n == 1) check("busy_running", busy, 1);
            if (ovr_cyc > 0 && n == ovr_cyc + 1) check("overrun_set", overrun, 1);
            if (n == EXP_LAT - 1) pre = filt_out;
            if (filt_complete) begin
                pulses++;
                if (lat == 0) begin lat = n; at_pulse = filt_out; end
            end
        end
        if (ovr_cyc > 0) exp_ovr = 1'b1;
        check("pulse_latency", lat, EXP_LAT);
        check("filtout_at_pulse", at_pulse, exp_out);
        check("filtout_pre_pulse", pre, exp_out);
        check("pulse_count", pulses, 1);
        check("filtout_hold", filt_out, exp_out);
        check("overrun_state", overrun, exp_ovr);
    endtask

    initial begin
        int pulses;
        n_checks = 0; n_pass = 0; exp_ovr = 1'b0;
        rst = 1'b1; sample_valid = 1'b0; ref_in = '0; err = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_filtout", filt_out, 0);
        check("rst_complete", filt_complete, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;

`ifdef ANC_LMS_ADAPT_EN
        run_sample(11'h100, 11'h000, 0, MIN_GAP, 11'h000);
        run_sample(11'h000, 11'h200, 0, MIN_GAP, 11'h000);
        run_sample(11'h100, 11'h000, 0, MIN_GAP, 11'h080);
        // Drive coefficients to the positive rail, then swing the output negative.
        for (int i = 0; i < 6; i++) run_sample(11'h3FF, 11'h3FF, 0, MIN_GAP, (i == 5) ? 11'h3FF : -1);
        for (int i = 0; i < 16; i++) run_sample(11'h7FF, 11'h000, 0, MIN_GAP, (i == 15) ? 11'h7FF : -1);
        // Flush, then a unit impulse exposes w[0]: 32767/4096 floors to 7.
        for (int i = 0; i < 16; i++) run_sample(11'h000, 11'h000, 0, MIN_GAP, -1);
        run_sample(11'h001, 11'h000, 0, MIN_GAP, 11'h007);
`else
        run_sample(11'h4C8, 11'($urandom), 0, MIN_GAP, 11'h4C8);
        run_sample(11'h400, 11'($urandom), 0, MIN_GAP, 11'h000);
`endif

        // Back-to-back at minimum spacing.
        for (int i = 0; i < 20; i++) run_sample(11'($urandom), 11'($urandom), 0, MIN_GAP, -1);

        // Overrun: extra strobe at cycle 10 is dropped; flag stays sticky.
        run_sample(11'($urandom), 11'($urandom), 10, MIN_GAP + 10, -1);
        run_sample(11'($urandom), 11'($urandom), 0, MIN_GAP, -1);

        // Reset mid-MAC, colliding with a SampleValid.
        @(negedge clk);
        ref_in = 11'($urandom); err = 11'($urandom); sample_valid = 1'b1;
        for (int n = 1; n <= RST_CYC; n++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            if (n == RST_CYC) begin rst = 1'b1; sample_valid = 1'b1; end
        end
        @(negedge clk);
        rst = 1'b0; sample_valid = 1'b0;
        check("midrst_filtout", filt_out, 0);
        check("midrst_complete", filt_complete, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun, 0);
        pulses = 0;
        repeat (3 * TAPS + 10) begin
            @(negedge clk);
            if (filt_complete) pulses++;
        end
        check("midrst_no_pulse", pulses, 0);
        check("midrst_stays_idle", busy, 0);
        model_reset();
        exp_ovr = 1'b0;

`ifdef ANC_LMS_ADAPT_EN
        run_sample(11'h100, 11'h000, 0, MIN_GAP, 11'h000);
        run_sample(11'h000, 11'h200, 0, MIN_GAP, 11'h000);
        run_sample(11'h100, 11'h000, 0, MIN_GAP, 11'h080);
`else
        run_sample(11'h4C8, 11'($urandom), 0, MIN_GAP, 11'h4C8);
`endif
        for (int i = 0; i < 8; i++) run_sample(11'($urandom), 11'($urandom), 0, MIN_GAP, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
